// File: rtl/mem_bus_arb.sv
// Two-requester (IF/MEM) arbiter for one shared single-port memory bus.
// Optional BUS_TIMEOUT_EN aborts a transfer after MAX_WAIT unacked cycles.
module mem_bus_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_sel,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ack,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_sel,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_ack,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_bus_err
);

  typedef enum logic [1:0] {
    IDLE, BUSY_IF, BUSY_MEM, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              last_mem_q, last_mem_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              grant_mem;
  logic              grant_if;
  logic              finish;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          expire;
`endif

  // MEM wins a tie unless it won the previous one
  assign grant_mem = i_mem_req & (~i_if_req | ~last_mem_q);
  assign grant_if  = i_if_req & ~grant_mem;

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = '0;
    mem_rdata_d = '0;
    finish      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
    expire      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d     = BUSY_MEM;
          last_mem_d  = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = i_mem_we;
          bus_sel_d   = i_mem_sel;
          bus_addr_d  = i_mem_addr;
          bus_wdata_d = i_mem_wdata;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          last_mem_d  = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = i_if_addr;
          bus_wdata_d = '0;
        end
`ifdef BUS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      BUSY_IF, BUSY_MEM: begin
        if (i_bus_ack) begin
          finish = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          finish    = 1'b1;
          expire    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
        if (finish) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_bus_rdata;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus_we_q ? '0 : i_bus_rdata;
          end
`ifdef BUS_TIMEOUT_EN
          if (expire) begin
            if_rdata_d  = '0;
            mem_rdata_d = '0;
          end
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign o_bus_err = bus_err_q;
`else
  assign o_bus_err = (MAX_WAIT < 0);
`endif

  assign o_bus_req   = bus_req_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_sel   = bus_sel_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_if_ack    = if_ack_q;
  assign o_mem_ack   = mem_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_mem_rdata = mem_rdata_q;
  assign o_stall_if  = i_if_req & ~if_ack_q;
  assign o_stall_mem = i_mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed self-checking bench for mem_bus_arb.
// Timeout scenarios follow BUS_TIMEOUT_EN when it is defined.
module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ack;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [3:0]  i_mem_sel;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_ack;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;
  logic        o_stall_if;
  logic        o_stall_mem;
  logic        o_bus_err;

  int total = 0;
  int bad   = 0;

  mem_bus_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we),
    .i_mem_sel(i_mem_sel), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .o_mem_rdata(o_mem_rdata),
    .o_mem_ack(o_mem_ack), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_sel(o_bus_sel),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    smp();
    total++;
    if (o_bus_req !== 1'b0) begin
      bad++; $display("FAIL rst_bus_req got=%b exp=0", o_bus_req);
    end
    total++;
    if ({o_if_ack, o_mem_ack, o_bus_err} !== 3'b000) begin
      bad++; $display("FAIL rst_acks got=%b exp=000", {o_if_ack, o_mem_ack, o_bus_err});
    end
    total++;
    if ({o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata} !== 128'd0) begin
      bad++; $display("FAIL rst_data got=%h %h %h %h exp=0", o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata);
    end
    total++;
    if ({o_bus_we, o_bus_sel} !== 5'd0) begin
      bad++; $display("FAIL rst_we_sel got=%b exp=0", {o_bus_we, o_bus_sel});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h40;
    smp();
    total++;
    if ({o_stall_if, o_bus_req} !== 2'b10) begin
      bad++; $display("FAIL fetch_c0 got stall/req=%b exp=10", {o_stall_if, o_bus_req});
    end
    tick();
    i_bus_ack = 1'b1; i_bus_rdata = 32'h3C010001;
    smp();
    total++;
    if ({o_bus_req, o_bus_we, o_bus_sel, o_stall_if} !== 7'b1_0_1111_1) begin
      bad++; $display("FAIL fetch_c1_ctl got=%b exp=1011111", {o_bus_req, o_bus_we, o_bus_sel, o_stall_if});
    end
    total++;
    if (o_bus_addr !== 32'h40) begin
      bad++; $display("FAIL fetch_c1_addr got=%h exp=00000040", o_bus_addr);
    end
    tick();
    i_bus_ack = 1'b0;
    smp();
    total++;
    if ({o_if_ack, o_mem_ack, o_bus_req, o_stall_if} !== 4'b1000) begin
      bad++; $display("FAIL fetch_c2_ack got=%b exp=1000", {o_if_ack, o_mem_ack, o_bus_req, o_stall_if});
    end
    total++;
    if (o_if_rdata !== 32'h3C010001 || o_mem_rdata !== 32'd0) begin
      bad++; $display("FAIL fetch_c2_rdata got=%h/%h exp=3c010001/0", o_if_rdata, o_mem_rdata);
    end
    tick();
    i_if_req = 1'b0;
    smp();
    total++;
    if (o_if_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_c3_ack got=%b exp=0", o_if_ack);
    end
  endtask

  task automatic test_write_wait;
    tick();
    i_mem_req = 1'b1; i_mem_we = 1'b1; i_mem_sel = 4'b0011;
    i_mem_addr = 32'h100; i_mem_wdata = 32'hDEADBEEF;
    i_bus_rdata = 32'h12345678; i_bus_ack = 1'b0;
    smp();
    total++;
    if (o_stall_mem !== 1'b1) begin
      bad++; $display("FAIL wr_stall_c0 got=%b exp=1", o_stall_mem);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin
        i_mem_addr = 32'h999; i_mem_wdata = 32'h0; i_mem_sel = 4'hF;
      end
      if (k == 4) i_bus_ack = 1'b1;
      smp();
      total++;
      if ({o_bus_req, o_bus_we, o_bus_sel, o_mem_ack} !== 7'b1_1_0011_0) begin
        bad++; $display("FAIL wr_ctl_c%0d got=%b exp=1100110", k, {o_bus_req, o_bus_we, o_bus_sel, o_mem_ack});
      end
      total++;
      if (o_bus_addr !== 32'h100 || o_bus_wdata !== 32'hDEADBEEF) begin
        bad++; $display("FAIL wr_data_c%0d got=%h/%h exp=100/deadbeef", k, o_bus_addr, o_bus_wdata);
      end
    end
    tick();
    i_bus_ack = 1'b0;
    smp();
    total++;
    if ({o_mem_ack, o_if_ack, o_bus_req, o_stall_mem} !== 4'b1000) begin
      bad++; $display("FAIL wr_c5_ack got=%b exp=1000", {o_mem_ack, o_if_ack, o_bus_req, o_stall_mem});
    end
    total++;
    if (o_mem_rdata !== 32'd0) begin
      bad++; $display("FAIL wr_c5_rdata got=%h exp=0", o_mem_rdata);
    end
    tick();
    i_mem_req = 1'b0; i_mem_we = 1'b0;
    smp();
    total++;
    if (o_mem_ack !== 1'b0) begin
      bad++; $display("FAIL wr_c6_ack got=%b exp=0", o_mem_ack);
    end
  endtask

  task automatic test_contention;
    logic [8:0]  exp_mem;
    logic [8:0]  exp_if;
    logic [31:0] exp_a;
    exp_mem = 9'b100000100;
    exp_if  = 9'b000100000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) begin
        i_if_req = 1'b1; i_if_addr = 32'h80;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF;
        i_mem_addr = 32'h300; i_bus_ack = 1'b1;
      end
      if (k == 6) i_if_req = 1'b0;
      i_bus_rdata = 32'hA0000000 + k;
      smp();
      total++;
      if (o_mem_ack !== exp_mem[k] || o_if_ack !== exp_if[k]) begin
        bad++; $display("FAIL cont_ack_c%0d got mem/if=%b%b exp=%b%b", k, o_mem_ack, o_if_ack, exp_mem[k], exp_if[k]);
      end
      if (k == 1 || k == 4 || k == 7) begin
        exp_a = (k == 4) ? 32'h80 : 32'h300;
        total++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== exp_a) begin
          bad++; $display("FAIL cont_bus_c%0d got=%b/%h exp=1/%h", k, o_bus_req, o_bus_addr, exp_a);
        end
      end
      if (exp_mem[k]) begin
        total++;
        if (o_mem_rdata !== 32'hA0000000 + k - 1) begin
          bad++; $display("FAIL cont_mrd_c%0d got=%h exp=%h", k, o_mem_rdata, 32'hA0000000 + k - 1);
        end
      end
      if (exp_if[k]) begin
        total++;
        if (o_if_rdata !== 32'hA0000000 + k - 1 || o_mem_rdata !== 32'd0) begin
          bad++; $display("FAIL cont_ird_c%0d got=%h/%h exp=%h/0", k, o_if_rdata, o_mem_rdata, 32'hA0000000 + k - 1);
        end
      end
    end
    tick();
    i_mem_req = 1'b0; i_bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    tick();
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h200;
    i_bus_ack = 1'b0;
    tick();
    smp();
    total++;
    if (o_bus_req !== 1'b1) begin
      bad++; $display("FAIL rmid_busy got=%b exp=1", o_bus_req);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (o_bus_req !== 1'b0) begin
      bad++; $display("FAIL rmid_async got=%b exp=0", o_bus_req);
    end
    i_mem_req = 1'b0;
    tick();
    rst = 1'b0;
    i_bus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      total++;
      if ({o_mem_ack, o_if_ack, o_bus_req} !== 3'b000) begin
        bad++; $display("FAIL rmid_late_c%0d got=%b exp=000", k, {o_mem_ack, o_if_ack, o_bus_req});
      end
    end
    i_bus_ack = 1'b0;
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h44;
    tick();
    smp();
    total++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h44) begin
      bad++; $display("FAIL rmid_idle got=%b/%h exp=1/00000044", o_bus_req, o_bus_addr);
    end
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0; i_if_req = 1'b0;
    smp();
    total++;
    if (o_if_ack !== 1'b1) begin
      bad++; $display("FAIL rmid_fetch_ack got=%b exp=1", o_if_ack);
    end
    tick();
  endtask

  task automatic test_timeout;
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h48;
    i_bus_rdata = 32'h55AA55AA; i_bus_ack = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      smp();
      total++;
      if (k <= 15) begin
        if ({o_bus_req, o_if_ack, o_bus_err} !== 3'b100) begin
          bad++; $display("FAIL to_wait_c%0d got=%b exp=100", k, {o_bus_req, o_if_ack, o_bus_err});
        end
      end else begin
        if ({o_bus_req, o_if_ack, o_bus_err} !== 3'b011 || o_if_rdata !== 32'd0) begin
          bad++; $display("FAIL to_expire got=%b/%h exp=011/0", {o_bus_req, o_if_ack, o_bus_err}, o_if_rdata);
        end
      end
    end
    tick();
    i_if_req = 1'b0;
    smp();
    total++;
    if ({o_if_ack, o_bus_err} !== 2'b00) begin
      bad++; $display("FAIL to_after got=%b exp=00", {o_if_ack, o_bus_err});
    end
    tick();
    i_if_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) i_bus_ack = 1'b1;
      smp();
      total++;
      if ({o_bus_req, o_bus_err} !== 2'b10) begin
        bad++; $display("FAIL tob_wait_c%0d got=%b exp=10", k, {o_bus_req, o_bus_err});
      end
    end
    tick();
    i_bus_ack = 1'b0;
    smp();
    total++;
    if ({o_if_ack, o_bus_err} !== 2'b10 || o_if_rdata !== 32'h55AA55AA) begin
      bad++; $display("FAIL tob_done got=%b/%h exp=10/55aa55aa", {o_if_ack, o_bus_err}, o_if_rdata);
    end
    tick();
    i_if_req = 1'b0;
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      smp();
      total++;
      if ({o_bus_req, o_if_ack, o_bus_err, o_stall_if} !== 4'b1001) begin
        bad++; $display("FAIL nto_wait_c%0d got=%b exp=1001", k, {o_bus_req, o_if_ack, o_bus_err, o_stall_if});
      end
    end
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    smp();
    total++;
    if ({o_if_ack, o_bus_err} !== 2'b10 || o_if_rdata !== 32'h55AA55AA) begin
      bad++; $display("FAIL nto_done got=%b/%h exp=10/55aa55aa", {o_if_ack, o_bus_err}, o_if_rdata);
    end
    tick();
    i_if_req = 1'b0;
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0;
    i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_sel = '0;
    i_mem_addr = '0; i_mem_wdata = '0;
    i_bus_rdata = '0; i_bus_ack = 1'b0;
    test_reset();
    test_fetch();
    test_write_wait();
    test_contention();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
